// File: rtl/alu_lab_pkg.sv
// alu_lab_pkg: sequencer state encodings and ALU opcode constants shared with the ALU mux
package alu_lab_pkg;
  localparam logic [2:0] ST_GET_A  = 3'd0;
  localparam logic [2:0] ST_GET_B  = 3'd1;
  localparam logic [2:0] ST_GET_OP = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_SHOW   = 3'd4;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_NOT = 3'd4;
endpackage

// File: rtl/btn_step_sync.sv
// btn_step_sync: two-flop synchronizer for the step button plus a one-cycle rising-edge pulse
module btn_step_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic step
);
  logic sync1, sync2, prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {sync1, sync2, prev} <= '0;
    else {sync1, sync2, prev} <= {btn, sync1, sync2};
  assign step = sync2 & ~prev;
endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: steps operand A, operand B and opcode/Cin in from switches, then captures the ALU result
module alu_operand_sequencer
  import alu_lab_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw,
  input  logic         btn,
  input  logic         clr,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic         Cin,
  output logic [2:0]   op,
  input  logic [N-1:0] Y_in,
  input  logic         Cout_in,
  output logic [N-1:0] result,
  output logic         carry,
  output logic         zero,
  output logic         valid,
  output logic [2:0]   state_dbg
);
  logic [2:0] state, st_nxt;
  logic step;
  btn_step_sync u_sync (.clk(clk), .rst_n(rst_n), .btn(btn), .step(step));
  always_comb
    st_nxt = clr                           ? ST_GET_A  :
             state == ST_EXEC              ? ST_SHOW   :
             state >  ST_SHOW              ? ST_GET_A  :
             !step                         ? state     :
             state == ST_GET_A             ? ST_GET_B  :
             state == ST_GET_B             ? ST_GET_OP :
             state == ST_GET_OP            ? ST_EXEC   : ST_GET_A;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= ST_GET_A;
      A      <= '0;
      B      <= '0;
      Cin    <= 1'b0;
      op     <= '0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      valid  <= 1'b0;
    end else begin
      state <= st_nxt;
      if (!clr && step && state == ST_GET_A) A <= sw;
      if (!clr && step && state == ST_GET_B) B <= sw;
      if (!clr && step && state == ST_GET_OP) begin
        op  <= sw[2:0];
        Cin <= sw[N-1];
      end
      if (!clr && state == ST_EXEC) begin
        result <= Y_in;
        carry  <= Cout_in;
        zero   <= (Y_in == '0);
      end
      if (clr || (step && state == ST_GET_A)) valid <= 1'b0;
      else if (state == ST_EXEC) valid <= 1'b1;
    end
  assign state_dbg = state;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: table-driven and corner-case checks of the operand sequencer against a bench ALU model
module tb_alu_operand_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, btn = 1'b0, clr = 1'b0;
  logic [3:0] sw = '0, A, B, Y_in, result;
  logic Cin, Cout_in, carry, zero, valid;
  logic [2:0] op, state_dbg;
  logic [4:0] add_s, sub_s;
  int checks = 0, failures = 0;
  typedef struct {
    logic [3:0] a, b, s, r;
    logic c, z;
  } vec_t;
  vec_t vecs[6];
  vec_t sb[$];
  always #5 clk = ~clk;
  alu_operand_sequencer #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn), .clr(clr),
    .A(A), .B(B), .Cin(Cin), .op(op), .Y_in(Y_in), .Cout_in(Cout_in),
    .result(result), .carry(carry), .zero(zero), .valid(valid), .state_dbg(state_dbg)
  );
  always_comb begin
    add_s   = {1'b0, A} + {1'b0, B} + {4'b0, Cin};
    sub_s   = {1'b0, A} + {1'b0, ~B} + 5'd1;
    Y_in    = op == 3'd0 ? add_s[3:0] : op == 3'd1 ? sub_s[3:0] : op == 3'd2 ? (A & B) : op == 3'd3 ? (A | B) : ~B;
    Cout_in = op == 3'd0 ? add_s[4] : op == 3'd1 ? sub_s[4] : 1'b0;
  end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic press(input logic [3:0] v);
    @(negedge clk);
    sw  = v;
    btn = 1'b1;
    repeat (4) @(negedge clk);
    btn = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic wait_show_and_compare();
    vec_t e;
    for (int i = 0; i < 20 && !valid; i++) @(negedge clk);
    chk("valid_timeout", valid, 1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("A", A, e.a);
    chk("B", B, e.b);
    chk("op", op, e.s[2:0]);
    chk("Cin", Cin, e.s[3]);
    chk("result", result, e.r);
    chk("carry", carry, e.c);
    chk("zero", zero, e.z);
    chk("state_show", state_dbg, 4);
  endtask
  initial begin
    vecs[0] = '{a:4'b1010, b:4'b0110, s:4'b1100, r:4'b1001, c:1'b0, z:1'b0};
    vecs[1] = '{a:4'hF, b:4'h1, s:4'h0, r:4'h0, c:1'b1, z:1'b1};
    vecs[2] = '{a:4'h3, b:4'h4, s:4'h8, r:4'h8, c:1'b0, z:1'b0};
    vecs[3] = '{a:4'h5, b:4'h5, s:4'h1, r:4'h0, c:1'b1, z:1'b1};
    vecs[4] = '{a:4'hC, b:4'hA, s:4'h2, r:4'h8, c:1'b0, z:1'b0};
    vecs[5] = '{a:4'h1, b:4'h2, s:4'h3, r:4'h3, c:1'b0, z:1'b0};
    repeat (2) @(negedge clk);
    chk("rst_state", state_dbg, 0);
    chk("rst_valid", valid, 0);
    chk("rst_A", A, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    foreach (vecs[i]) begin
      if (state_dbg == 3'd4) press(4'h0);
      chk("state_get_a", state_dbg, 0);
      press(vecs[i].a);
      chk("valid_cleared", valid, 0);
      press(vecs[i].b);
      sb.push_back(vecs[i]);
      press(vecs[i].s);
      wait_show_and_compare();
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_A", A, 0);
    chk("arst_B", B, 0);
    chk("arst_Cin", Cin, 0);
    chk("arst_op", op, 0);
    chk("arst_result", result, 0);
    chk("arst_carry", carry, 0);
    chk("arst_zero", zero, 0);
    chk("arst_valid", valid, 0);
    chk("arst_state", state_dbg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    sw  = 4'h5;
    btn = 1'b1;
    @(posedge clk); #1;
    chk("edge_t1_state", state_dbg, 0);
    @(posedge clk); #1;
    chk("edge_t2_state", state_dbg, 0);
    @(posedge clk); #1;
    chk("edge_t3_state", state_dbg, 1);
    chk("edge_t3_A", A, 5);
    repeat (20) @(negedge clk);
    chk("hold_state", state_dbg, 1);
    btn = 1'b0;
    repeat (3) @(negedge clk);
    press(4'h3);
    chk("get_op_state", state_dbg, 2);
    chk("get_op_B", B, 3);
    @(negedge clk);
    sw  = 4'h7;
    btn = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_state", state_dbg, 0);
    chk("clr_valid", valid, 0);
    chk("clr_op", op, 0);
    chk("clr_B_kept", B, 3);
    btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("clr_no_late_step", state_dbg, 0);
    press(4'h2);
    press(4'h9);
    sb.push_back('{a:4'h2, b:4'h9, s:4'hB, r:4'hB, c:1'b0, z:1'b0});
    @(negedge clk);
    sw  = 4'hB;
    btn = 1'b1;
    repeat (3) @(negedge clk);
    chk("exec_state", state_dbg, 3);
    force dut.step = 1'b1;
    @(posedge clk);
    #1 release dut.step;
    btn = 1'b0;
    repeat (5) @(negedge clk);
    chk("exec_press_ignored", state_dbg, 4);
    wait_show_and_compare();
    press(4'h0);
    chk("show_to_get_a", state_dbg, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
